// File: rtl/alu_uart_frame_ctrl_if.sv
// rtl/alu_uart_frame_ctrl_if.sv - UART/ALU side signal bundle for the frame controller
//
// Signals:
//   i_rx_data    byte received by the UART, valid with i_rx_done
//   i_rx_done    one-cycle pulse per received byte
//   o_tx_data    byte to transmit, stable from o_tx_start until i_tx_done
//   o_tx_start   one-cycle transmit request
//   i_tx_done    one-cycle pulse when the UART finished a byte
//   o_alu_a      operand A to the ALU
//   o_alu_b      operand B to the ALU
//   o_alu_op     ALU opcode
//   i_alu_result combinational ALU result
//   o_busy       high from execution through the end of the status byte
// Modports:
//   master       the frame controller
//   slave        the UART core and ALU around it
interface alu_uart_frame_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_CODE = 6
);
    logic [7:0]         i_rx_data;
    logic               i_rx_done;
    logic [7:0]         o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_CODE-1:0] o_alu_op;
    logic [NB_DATA-1:0] i_alu_result;
    logic               o_busy;

    modport master (
        input  i_rx_data,
        input  i_rx_done,
        output o_tx_data,
        output o_tx_start,
        input  i_tx_done,
        output o_alu_a,
        output o_alu_b,
        output o_alu_op,
        input  i_alu_result,
        output o_busy
    );

    modport slave (
        output i_rx_data,
        output i_rx_done,
        input  o_tx_data,
        input  o_tx_start,
        output i_tx_done,
        input  o_alu_a,
        input  o_alu_b,
        input  o_alu_op,
        output i_alu_result,
        input  o_busy
    );
endinterface

// File: rtl/alu_uart_frame_ctrl.sv
// rtl/alu_uart_frame_ctrl.sv - byte-framed operand/opcode collector and result/status sender for the ALU
//
// Ports:
//   i_clk    system clock
//   i_reset  asynchronous active-high reset
//   bus      alu_uart_frame_ctrl_if.master: UART rx/tx handshake, ALU operands/result, busy
//
// A frame is NBYTES bytes of A, NBYTES bytes of B and one opcode byte, each
// operand LSB byte first. The reply is the result bytes (LSB first) followed by
// a status byte {timeout, 5'b0, bad_opcode, zero}. A bad opcode replies with the
// status byte only; an inter-byte timeout replies with 0x80 only.
module alu_uart_frame_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_CODE     = 6,
    parameter int NB_BYTE     = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    alu_uart_frame_ctrl_if.master bus
);

    localparam int NBYTES = NB_DATA / NB_BYTE;
    localparam int CW     = $clog2(NBYTES + 1);
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] LAST_BYTE    = CW'(NBYTES - 1);
    localparam logic [TW-1:0] TO_LIMIT     = TW'(TIMEOUT_CYC);
    localparam logic [7:0]    STAT_TIMEOUT = 8'h80;
    localparam logic [7:0]    STAT_BAD_OP  = 8'h02;

    typedef enum logic [2:0] {
        RX_A      = 3'd0,
        RX_B      = 3'd1,
        RX_OP     = 3'd2,
        EXEC      = 3'd3,
        TX_RES    = 3'd4,
        WAIT_RES  = 3'd5,
        TX_STAT   = 3'd6,
        WAIT_STAT = 3'd7
    } state_t;

    state_t             state;
    logic [CW-1:0]      byte_cnt;
    logic [TW-1:0]      to_cnt;
    logic [NB_DATA-1:0] a_reg;
    logic [NB_DATA-1:0] b_reg;
    logic [NB_CODE-1:0] op_reg;
    logic               bad_op;
    logic [NB_DATA-1:0] res_reg;
    logic [7:0]         status;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               busy;

    // Concatenating the new byte above the register and dropping the low byte
    // shifts it in from the top; this stays legal for a single-byte operand.
    logic [NB_DATA+NB_BYTE-1:0] a_cat;
    logic [NB_DATA+NB_BYTE-1:0] b_cat;
    logic [NB_DATA+NB_BYTE-1:0] res_cat;
    logic                       bad_code;
    logic                       frame_open;
    logic                       res_zero;

    assign a_cat    = {bus.i_rx_data, a_reg};
    assign b_cat    = {bus.i_rx_data, b_reg};
    assign res_cat  = {{NB_BYTE{1'b0}}, res_reg};
    assign bad_code = (bus.i_rx_data >> NB_CODE) != 8'h00;
    assign res_zero = (bus.i_alu_result == '0);

    // Idle cycles only count once a frame has started; an empty RX_A may idle forever.
    assign frame_open = ((state == RX_A) && (byte_cnt != '0)) ||
                        (state == RX_B) || (state == RX_OP);

    assign bus.o_alu_a    = a_reg;
    assign bus.o_alu_b    = b_reg;
    assign bus.o_alu_op   = op_reg;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_tx_start = tx_start;
    assign bus.o_busy     = busy;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= RX_A;
            byte_cnt <= '0;
            to_cnt   <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            bad_op   <= 1'b0;
            res_reg  <= '0;
            status   <= 8'h00;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            busy     <= 1'b0;
        end else if (frame_open && !bus.i_rx_done) begin
            // A byte on the limit cycle takes the else path above, so it always wins.
            if (to_cnt == TO_LIMIT) begin
                state    <= TX_STAT;
                byte_cnt <= '0;
                to_cnt   <= '0;
                status   <= STAT_TIMEOUT;
                tx_data  <= STAT_TIMEOUT;
                tx_start <= 1'b1;
                busy     <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end else begin
            case (state)
                RX_A: begin
                    if (bus.i_rx_done) begin
                        a_reg  <= a_cat[NB_DATA+NB_BYTE-1:NB_BYTE];
                        to_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= RX_B;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                RX_B: begin
                    if (bus.i_rx_done) begin
                        b_reg  <= b_cat[NB_DATA+NB_BYTE-1:NB_BYTE];
                        to_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= RX_OP;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                RX_OP: begin
                    if (bus.i_rx_done) begin
                        op_reg   <= bus.i_rx_data[NB_CODE-1:0];
                        bad_op   <= bad_code;
                        to_cnt   <= '0;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end

                // The ALU has seen the new opcode for this cycle; capture its result
                // and launch the first reply byte straight away.
                EXEC: begin
                    res_reg  <= bus.i_alu_result;
                    tx_start <= 1'b1;
                    byte_cnt <= '0;
                    if (bad_op) begin
                        status  <= STAT_BAD_OP;
                        tx_data <= STAT_BAD_OP;
                        state   <= TX_STAT;
                    end else begin
                        status  <= {7'b0, res_zero};
                        tx_data <= bus.i_alu_result[NB_BYTE-1:0];
                        state   <= TX_RES;
                    end
                end

                TX_RES: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_RES;
                end

                WAIT_RES: begin
                    if (bus.i_tx_done) begin
                        tx_start <= 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            tx_data  <= status;
                            state    <= TX_STAT;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            res_reg  <= res_cat[NB_DATA+NB_BYTE-1:NB_BYTE];
                            tx_data  <= res_cat[2*NB_BYTE-1:NB_BYTE];
                            state    <= TX_RES;
                        end
                    end
                end

                TX_STAT: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_STAT;
                end

                WAIT_STAT: begin
                    if (bus.i_tx_done) begin
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                        busy     <= 1'b0;
                        state    <= RX_A;
                    end
                end

                default: begin
                    state <= RX_A;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_uart_frame_ctrl.md
# alu_uart_frame_ctrl

Frame controller between the UART core (`uart`) and the ALU inside `top`. It generalises the fixed three-byte A/B/opcode exchange to operands of any width that is a multiple of 8 bits, sent LSB byte first. It returns the result bytes followed by a status byte. It also adds inter-byte timeout recovery and rejection of illegal opcodes.

## Interface
Parameters:
- `NB_DATA`, 8: operand and result width; must be a multiple of 8 (8, 16, 24, 32).
- `NB_CODE`, 6: ALU opcode width; must be ≤ 8.
- `NB_BYTE`, 8: UART byte width; fixed at 8.
- `TIMEOUT_CYC`, 200000: maximum number of idle clock cycles allowed between bytes of one frame.

Ports:
- `i_clk`, in, 1: system clock.
- `i_reset`, in, 1: reset, asynchronous and active-high.
- `i_rx_data`, in, 8: received byte from the UART; valid when `i_rx_done`=1.
- `i_rx_done`, in, 1: one-cycle pulse when a byte has been received.
- `o_tx_data`, out, 8: byte to transmit; held stable from `o_tx_start` until `i_tx_done`.
- `o_tx_start`, out, 1: one-cycle transmit request.
- `i_tx_done`, in, 1: one-cycle pulse when the UART has finished sending the byte.
- `o_alu_a`, out, NB_DATA: operand A to the ALU.
- `o_alu_b`, out, NB_DATA: operand B to the ALU.
- `o_alu_op`, out, NB_CODE: opcode to the ALU.
- `i_alu_result`, in, NB_DATA: combinational ALU result.
- `o_busy`, out, 1: high from EXEC through the end of the status byte.

## Operation
- NBYTES = NB_DATA/8. A frame is NBYTES bytes of A, then NBYTES bytes of B, then 1 opcode byte, all LSB byte first.
- Each received byte is shifted into the top of its register, so after NBYTES bytes the first byte sits in bits [7:0].
- FSM states:
  - RX_A: collecting A. After NBYTES bytes → RX_B.
  - RX_B: collecting B. After NBYTES bytes → RX_OP.
  - RX_OP: on the opcode byte → EXEC. Bits [7:NB_CODE] nonzero marks the frame as a bad opcode.
  - EXEC: one cycle; latches `i_alu_result` into the result register. Valid opcode → TX_RES. Bad opcode → TX_STAT.
  - TX_RES: pulses `o_tx_start` with the next result byte (LSB first) → WAIT_RES.
  - WAIT_RES: on `i_tx_done`, go to TX_RES if bytes remain, otherwise → TX_STAT.
  - TX_STAT: pulses `o_tx_start` with the status byte → WAIT_STAT.
  - WAIT_STAT: on `i_tx_done` → RX_A; byte counter and timeout counter cleared.
- Status byte:
  - bit0: zero flag (latched result == 0; forced to 0 for a bad opcode).
  - bit1: bad opcode.
  - bit7: timeout.
  - bits 6..2: always 0.
- Operand and opcode registers drive `o_alu_a`, `o_alu_b` and `o_alu_op` directly. They hold their values until overwritten by the next frame.
- Timeout:
  - The counter runs only while a frame is partially received: RX_A with byte count > 0, RX_B, or RX_OP.
  - It clears on every `i_rx_done`.
  - On reaching TIMEOUT_CYC it discards the partial frame, clears the byte counter, and goes to TX_STAT with status 0x80. Operand registers are left untouched.
- `i_rx_done` outside the RX states (EXEC through WAIT_STAT) is ignored; the byte is dropped.

## Timing
- Reset (asynchronous, immediate): state RX_A; all outputs 0; all counters 0. This applies mid-frame or mid-transmit alike. After reset the controller waits for a fresh frame and does not re-send anything.
- The `i_rx_done` of the opcode byte is followed by EXEC on the next cycle, then TX_RES. `o_tx_start` for result byte 0 therefore asserts 2 cycles after the opcode `i_rx_done`.
- `o_tx_start` is exactly 1 cycle wide.
- After an `i_tx_done`, the next `o_tx_start` asserts 1 cycle later: 1 cycle in TX_x after the WAIT_x transition.
- A timeout fires on the cycle the counter equals TIMEOUT_CYC. `o_tx_start` for the 0x80 status byte follows 1 cycle later.
- If `i_rx_done` arrives on the same cycle the counter would reach TIMEOUT_CYC, the byte wins: it is accepted and the counter clears.
- `o_busy` rises on entry to EXEC, or to TX_STAT after a timeout. It falls on the cycle the state returns to RX_A.

## Test plan
- NB_DATA=8, looped back through `uart` and `top`. Send 0x03, 0x08, opcode 0x20 (ADD) → TX 0x0B, then status 0x00.
- NB_DATA=16. Send 0x34, 0x12, 0x01, 0x00, 0x20 → `o_alu_a`=0x1234, `o_alu_b`=0x0001; TX 0x35, 0x12, then 0x00.
- NB_DATA=8. Send A=0x05, B=0x05, opcode 0x22 (SUB) → TX 0x00, then status 0x01.
- Opcode byte 0xE0 with NB_CODE=6 → no result bytes; TX status 0x02 only. The next frame 0x01, 0x01, 0x20 → TX 0x02, then 0x00.
- TIMEOUT_CYC=1000. Send A only, then idle 1000 cycles → TX 0x80. A subsequent full frame 0x03, 0x08, 0x20 → TX 0x0B, then 0x00. Also, a byte arriving at cycle 999 of the gap is accepted and no timeout occurs.
- Assert `i_reset` during WAIT_RES → outputs 0 immediately, no further `o_tx_start`. A following frame completes normally. Also, bytes sent while `o_busy`=1 do not corrupt the next frame.
